// File: rtl/add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package add_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_state_t;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry slice built from full-adder cells; the only arithmetic in the sequencer.

// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module nibble_adder
  import add_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;
  assign cout = c[NIB_W];

  // Ripple chain: carry from each cell feeds the next more significant cell.
  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer feeding WIDTH-bit operands through one shared nibble adder, LSB nibble first.
// After the last nibble pass, one extra RUN cycle copies the assembled result into the
// output registers, so out_sum/out_cout keep the previous result while a new add runs.
module nibble_serial_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  add_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;

  nibble_adder u_slice (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = out_sum;
    cout_d  = out_cout;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!last_q) begin
          res_d   = {nib_sum, res_q[WIDTH-1:NIB_W]};
          carry_d = nib_cout;
          a_d     = a_q >> NIB_W;
          b_d     = b_q >> NIB_W;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NIB - 1)) begin
            last_d = 1'b1;
          end
        end else begin
          sum_d   = res_q;
          cout_d  = carry_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      last_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      last_q    <= last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      out_sum   <= sum_d;
      out_cout  <= cout_d;
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      in_ready  <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for the nibble-serial adder sequencer (16-bit and 32-bit instances).
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [15:0] in_a, in_b, out_sum;

  logic        v32, rdy32, cin32, ov32, or32, co32, busy32;
  logic [31:0] a32, b32, s32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v32),
    .in_ready  (rdy32),
    .in_a      (a32),
    .in_b      (b32),
    .in_cin    (cin32),
    .out_valid (ov32),
    .out_ready (or32),
    .out_sum   (s32),
    .out_cout  (co32),
    .busy      (busy32)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one 16-bit add, scramble operands after accept, return cycles until out_valid.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int lat, output logic [15:0] s, output logic co);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL run16_ready_timeout got in_ready=%b exp=1", in_ready);
    end
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~c;
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick;
      lat++;
    end
    s  = out_sum;
    co = out_cout;
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic c,
                       output int lat, output logic [31:0] s, output logic co);
    int n;
    n = 0;
    while (!rdy32 && n < 50) begin
      tick;
      n++;
    end
    if (!rdy32) begin
      checks++;
      failures++;
      $display("FAIL run32_ready_timeout got in_ready=%b exp=1", rdy32);
    end
    a32 = a; b32 = b; cin32 = c; v32 = 1'b1;
    tick;
    v32 = 1'b0; a32 = ~a; b32 = ~b; cin32 = ~c;
    lat = 0;
    while (!ov32 && lat < 40) begin
      tick;
      lat++;
    end
    s  = s32;
    co = co32;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; or32 = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_sum !== 16'h0000) begin failures++; $display("FAIL reset_out_sum got=%h exp=0000", out_sum); end
    checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b1;
    in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_run got=%b exp=0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick;
      lat++;
    end
    checks++; if (lat != 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++; if (out_sum !== 16'h5555) begin failures++; $display("FAIL basic_sum got=%h exp=5555", out_sum); end
    checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", out_cout); end
    tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_idle_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    checks++; if (out_sum !== 16'h5555) begin failures++; $display("FAIL basic_sum_held got=%h exp=5555", out_sum); end
  endtask

  task automatic test_carry;
    logic [15:0] va [6] = '{16'hFFFF, 16'hFFFF, 16'hABCD, 16'h8000, 16'h0000, 16'h7FFF};
    logic [15:0] vb [6] = '{16'h0001, 16'h0000, 16'h1234, 16'h8000, 16'h0000, 16'h0000};
    logic        vc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] es [6] = '{16'h0000, 16'h0000, 16'hBE02, 16'h0000, 16'h0000, 16'h8000};
    logic        ec [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [15:0] s;
    logic co;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run16(va[i], vb[i], vc[i], lat, s, co);
      checks++; if (lat != 5) begin failures++; $display("FAIL carry_latency[%0d] got=%0d exp=5", i, lat); end
      checks++; if (s !== es[i]) begin failures++; $display("FAIL carry_sum[%0d] got=%h exp=%h", i, s, es[i]); end
      checks++; if (co !== ec[i]) begin failures++; $display("FAIL carry_cout[%0d] got=%b exp=%b", i, co, ec[i]); end
    end
    tick;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [15:0] s;
    logic co;
    out_ready = 1'b0;
    run16(16'h0F0F, 16'h0101, 1'b0, lat, s, co);
    checks++; if (s !== 16'h1010) begin failures++; $display("FAIL bp_sum got=%h exp=1010", s); end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
      tick;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_sum !== 16'h1010) begin failures++; $display("FAIL bp_sum_stable[%0d] got=%h exp=1010", i, out_sum); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_accept got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_midrun;
    int lat;
    logic [15:0] s;
    logic co;
    logic seen;
    out_ready = 1'b1;
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_valid got=%b exp=0", seen); end
    checks++; if (out_sum !== 16'h0000) begin failures++; $display("FAIL rst_mid_sum_cleared got=%h exp=0000", out_sum); end
    run16(16'h00FF, 16'h0001, 1'b0, lat, s, co);
    checks++; if (lat != 5) begin failures++; $display("FAIL rst_next_latency got=%0d exp=5", lat); end
    checks++; if (s !== 16'h0100) begin failures++; $display("FAIL rst_next_sum got=%h exp=0100", s); end
    checks++; if (co !== 1'b0) begin failures++; $display("FAIL rst_next_cout got=%b exp=0", co); end
    tick;
  endtask

  task automatic test_back_to_back;
    int acc_cyc [2];
    logic [15:0] res [2];
    int nacc, nres;
    logic acc;
    nacc = 0; nres = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    res[0] = '0; res[1] = '0;
    out_ready = 1'b1;
    in_a = 16'h1234; in_b = 16'h0001; in_cin = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      acc = in_ready && in_valid;
      tick;
      if (out_valid && nres < 2) begin
        res[nres] = out_sum;
        nres++;
      end
      if (acc && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 1) begin
          in_a = 16'h2000; in_b = 16'h0FFF; in_cin = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (nacc != 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", nacc); end
    checks++; if (nres != 2) begin failures++; $display("FAIL b2b_results got=%0d exp=2", nres); end
    checks++; if (acc_cyc[1] - acc_cyc[0] < 6) begin failures++; $display("FAIL b2b_gap got=%0d exp>=6", acc_cyc[1] - acc_cyc[0]); end
    checks++; if (res[0] !== 16'h1235) begin failures++; $display("FAIL b2b_sum0 got=%h exp=1235", res[0]); end
    checks++; if (res[1] !== 16'h3000) begin failures++; $display("FAIL b2b_sum1 got=%h exp=3000", res[1]); end
  endtask

  task automatic test_random16;
    int lat;
    logic [15:0] a, b, s;
    logic c, co;
    logic [16:0] exp_full;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      exp_full = 17'(a) + 17'(b) + 17'(c);
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) tick;
      run16(a, b, c, lat, s, co);
      checks++; if ({co, s} !== exp_full) begin failures++; $display("FAIL rand16[%0d] got=%b_%h exp=%b_%h", i, co, s, exp_full[16], exp_full[15:0]); end
      repeat ($urandom_range(0, 3)) tick;
      out_ready = 1'b1;
      tick;
    end
  endtask

  task automatic test_width32;
    int lat;
    logic [31:0] a, b, s;
    logic c, co;
    logic [32:0] exp_full;
    or32 = 1'b1;
    run32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat, s, co);
    checks++; if (lat != 9) begin failures++; $display("FAIL w32_latency got=%0d exp=9", lat); end
    checks++; if (s !== 32'h0000_0000) begin failures++; $display("FAIL w32_ripple_sum got=%h exp=00000000", s); end
    checks++; if (co !== 1'b1) begin failures++; $display("FAIL w32_ripple_cout got=%b exp=1", co); end
    run32(32'h1234_5678, 32'h8765_4321, 1'b0, lat, s, co);
    checks++; if (s !== 32'h9999_9999) begin failures++; $display("FAIL w32_sum got=%h exp=99999999", s); end
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom);
      exp_full = 33'(a) + 33'(b) + 33'(c);
      run32(a, b, c, lat, s, co);
      checks++; if ({co, s} !== exp_full) begin failures++; $display("FAIL rand32[%0d] got=%b_%h exp=%b_%h", i, co, s, exp_full[32], exp_full[31:0]); end
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_backpressure;
    test_reset_midrun;
    test_back_to_back;
    test_random16;
    test_width32;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
